spart_driver: RTL and testbench

SPART_DRIVER -- requirements
Module: spart_driver

---
 rtl/spart_pkg.sv | 59 +++++
 rtl/spart_driver.sv | 179 +++++++++++++++++
 tb/tb_spart_driver.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spart_pkg.sv
// spart_pkg -- shared constants for the SPART host-side driver.
//   * ioaddr register map of the SPART
//   * br_cfg baud-select encodings
//   * FSM state codes (plain localparams so older tools can consume them)
//   * spart_divisor(): 16x-oversample divisor for a baud select and clock rate
package spart_pkg;

  // SPART register map (ioaddr)
  localparam logic [1:0] ADDR_BUF    = 2'b00;  // tx/rx buffer
  localparam logic [1:0] ADDR_STATUS = 2'b01;  // status
  localparam logic [1:0] ADDR_DBL    = 2'b10;  // divisor low byte
  localparam logic [1:0] ADDR_DBH    = 2'b11;  // divisor high byte

  // br_cfg encodings
  localparam logic [1:0] BR_4800  = 2'b00;
  localparam logic [1:0] BR_9600  = 2'b01;
  localparam logic [1:0] BR_19200 = 2'b10;
  localparam logic [1:0] BR_38400 = 2'b11;

  // Divisor table for a 100 MHz system clock
  localparam int unsigned CLK_100M   = 100_000_000;
  localparam logic [15:0] DIV_4800   = 16'h0516;
  localparam logic [15:0] DIV_9600   = 16'h028B;
  localparam logic [15:0] DIV_19200  = 16'h0145;
  localparam logic [15:0] DIV_38400  = 16'h00A2;

  // FSM state codes
  localparam logic [2:0] ST_INIT_DBL = 3'd0;
  localparam logic [2:0] ST_INIT_DBH = 3'd1;
  localparam logic [2:0] ST_IDLE     = 3'd2;
  localparam logic [2:0] ST_RD_RX    = 3'd3;
  localparam logic [2:0] ST_WR_TX    = 3'd4;
  localparam logic [2:0] ST_RECOVER  = 3'd5;

  // The 100 MHz table is the reference; other clock rates use the same
  // floor(clk / (16 * baud)) rule the table was built with. clk_hz is a
  // parameter at every call site, so the divisions fold to constants.
  function automatic logic [15:0] spart_divisor(input logic [1:0] cfg,
                                                input int unsigned clk_hz);
    logic [15:0] div;
    if (clk_hz == CLK_100M) begin
      case (cfg)
        BR_4800:  div = DIV_4800;
        BR_9600:  div = DIV_9600;
        BR_19200: div = DIV_19200;
        default:  div = DIV_38400;
      endcase
    end else begin
      case (cfg)
        BR_4800:  div = 16'(clk_hz / 32'd76800);
        BR_9600:  div = 16'(clk_hz / 32'd153600);
        BR_19200: div = 16'(clk_hz / 32'd307200);
        default:  div = 16'(clk_hz / 32'd614400);
      endcase
    end
    return div;
  endfunction

endpackage

// File: rtl/spart_driver.sv
// spart_driver -- host-side driver FSM for a SPART (programmable UART).
// Programs the baud divisor after reset and on every br_cfg change, polls
// rda/tbr, reads received bytes out to the user and writes user bytes in.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous, active-low reset
//   br_cfg     baud select (00=4800, 01=9600, 10=19200, 11=38400)
//   iocs       SPART chip select, one-cycle strobe per access
//   iorw       1=read, 0=write
//   ioaddr     SPART register address
//   databus    bidirectional data; driven here only on write cycles
//   rda, tbr   SPART receive-data-available / transmit-buffer-ready
//   rx_char    last received byte; rx_valid pulses one cycle after the read
//   tx_char    user byte, sampled in the write cycle
//   tx_req     user transmit request, hold until tx_ack
//   tx_ack     one-cycle pulse in the cycle the user byte is written
//   dbg_state  current FSM state (spart_pkg ST_* codes)
//
// Handshake: tx_req/tx_char form a request held by the user; the transfer
// happens in the cycle tx_ack=1, after which tx_req may drop or change.
//
// Build option: SPART_DRIVER_ECHO_EN -- every received byte is held in a
// one-entry echo register and written back out before any user byte; no
// new byte is read while an echo is outstanding (rda stays asserted).
module spart_driver
  import spart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] br_cfg,
  output logic       iocs,
  output logic       iorw,
  output logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  input  logic       rda,
  input  logic       tbr,
  output logic [7:0] rx_char,
  output logic       rx_valid,
  input  logic [7:0] tx_char,
  input  logic       tx_req,
  output logic       tx_ack,
  output logic [2:0] dbg_state
);

  logic [2:0]  state_q, state_d;
  logic        live_q;               // 0 while in reset, gates all bus outputs
  logic [1:0]  br_cfg_q;             // br_cfg registered every cycle
  logic [1:0]  cfg_used_q, cfg_used_d;  // setting the divisor was written for
  logic [7:0]  rx_char_q, rx_char_d;
  logic        rx_valid_q, rx_valid_d;
  logic        echo_busy;
  logic        drive;
  logic [7:0]  wdata;
  logic [15:0] div_lo_word, div_hi_word;

`ifdef SPART_DRIVER_ECHO_EN
  logic        echo_pend_q, echo_pend_d;
  logic [7:0]  echo_q, echo_d;
  assign echo_busy = echo_pend_q;
`else
  assign echo_busy = 1'b0;
`endif

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    cfg_used_d = cfg_used_q;
    rx_char_d  = rx_char_q;
    rx_valid_d = 1'b0;
`ifdef SPART_DRIVER_ECHO_EN
    echo_pend_d = echo_pend_q;
    echo_d      = echo_q;
`endif
    case (state_q)
      ST_INIT_DBL: begin
        // Hold here for the first cycle out of reset so the low-byte write
        // is a real, full cycle with live outputs.
        if (live_q) begin
          state_d    = ST_INIT_DBH;
          cfg_used_d = br_cfg_q;
        end
      end
      ST_INIT_DBH: state_d = ST_RECOVER;
      ST_IDLE: begin
        if (br_cfg_q != cfg_used_q)      state_d = ST_INIT_DBL;
        else if (rda && !echo_busy)      state_d = ST_RD_RX;
        else if (tbr && (echo_busy || tx_req)) state_d = ST_WR_TX;
      end
      ST_RD_RX: begin
        rx_char_d  = databus;
        rx_valid_d = 1'b1;
`ifdef SPART_DRIVER_ECHO_EN
        echo_d      = databus;
        echo_pend_d = 1'b1;
`endif
        state_d = ST_RECOVER;
      end
      ST_WR_TX: begin
`ifdef SPART_DRIVER_ECHO_EN
        echo_pend_d = 1'b0;
`endif
        state_d = ST_RECOVER;
      end
      ST_RECOVER: state_d = ST_IDLE;
      default:    state_d = ST_INIT_DBL;
    endcase
  end

  // Bus outputs decode from the current state; everything is quiet in reset
  always_comb begin
    iocs        = 1'b0;
    iorw        = 1'b1;
    ioaddr      = ADDR_BUF;
    drive       = 1'b0;
    wdata       = 8'h00;
    tx_ack      = 1'b0;
    div_lo_word = spart_divisor(br_cfg_q, CLK_HZ);
    div_hi_word = spart_divisor(cfg_used_q, CLK_HZ);
    if (live_q) begin
      case (state_q)
        ST_INIT_DBL: begin
          iocs = 1'b1; iorw = 1'b0; ioaddr = ADDR_DBL; drive = 1'b1;
          wdata = div_lo_word[7:0];
        end
        ST_INIT_DBH: begin
          iocs = 1'b1; iorw = 1'b0; ioaddr = ADDR_DBH; drive = 1'b1;
          wdata = div_hi_word[15:8];
        end
        ST_RD_RX: begin
          iocs = 1'b1; iorw = 1'b1; ioaddr = ADDR_BUF;
        end
        ST_WR_TX: begin
          iocs = 1'b1; iorw = 1'b0; ioaddr = ADDR_BUF; drive = 1'b1;
`ifdef SPART_DRIVER_ECHO_EN
          wdata  = echo_busy ? echo_q : tx_char;
`else
          wdata  = tx_char;
`endif
          tx_ack = !echo_busy;
        end
        default: ;
      endcase
    end
  end

  assign databus   = drive ? wdata : 8'hzz;
  assign rx_char   = rx_char_q;
  assign rx_valid  = rx_valid_q;
  assign dbg_state = state_q;

  always_ff @(posedge clk) begin
    br_cfg_q <= br_cfg;
    if (!rst) begin
      state_q     <= ST_INIT_DBL;
      live_q      <= 1'b0;
      cfg_used_q  <= BR_4800;
      rx_char_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
`ifdef SPART_DRIVER_ECHO_EN
      echo_pend_q <= 1'b0;
      echo_q      <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      live_q      <= 1'b1;
      cfg_used_q  <= cfg_used_d;
      rx_char_q   <= rx_char_d;
      rx_valid_q  <= rx_valid_d;
`ifdef SPART_DRIVER_ECHO_EN
      echo_pend_q <= echo_pend_d;
      echo_q      <= echo_d;
`endif
    end
  end

endmodule

// File: tb/tb_spart_driver.sv
// tb_spart_driver -- bench for spart_driver. The bench plays the SPART:
// it drives rda/tbr, returns a byte on read cycles, and checks every bus
// access against an expected-transaction queue. Received bytes are checked
// against a second queue when rx_valid pulses.
// Build option SPART_DRIVER_ECHO_EN adds the expected echo writes.
module tb_spart_driver;
  import spart_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] br_cfg = 2'b01;
  logic       rda = 1'b0;
  logic       tbr = 1'b1;
  logic [7:0] tx_char = 8'h00;
  logic       tx_req = 1'b0;
  logic [7:0] spart_rx_data = 8'h00;
  wire        iocs, iorw, rx_valid, tx_ack;
  wire  [1:0] ioaddr;
  wire  [7:0] databus, rx_char;
  wire  [2:0] dbg_state;

  int n_vec = 0;
  int n_err = 0;
  int rd_cnt = 0;
  int ack_cnt = 0;

  // {iorw, ioaddr, data}
  logic [10:0] exp_q[$];
  logic [7:0]  exp_rx_q[$];

  spart_driver #(.CLK_HZ(100_000_000)) dut (
    .clk(clk), .rst(rst), .br_cfg(br_cfg), .iocs(iocs), .iorw(iorw),
    .ioaddr(ioaddr), .databus(databus), .rda(rda), .tbr(tbr),
    .rx_char(rx_char), .rx_valid(rx_valid), .tx_char(tx_char),
    .tx_req(tx_req), .tx_ack(tx_ack), .dbg_state(dbg_state)
  );

  // SPART side of the bus: return the receive byte on read cycles
  assign databus = (iocs && iorw) ? spart_rx_data : 8'hzz;

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Independent divisor table
  function automatic logic [15:0] tb_div(input logic [1:0] cfg);
    case (cfg)
      2'b00:   return 16'd1302;
      2'b01:   return 16'd651;
      2'b10:   return 16'd325;
      default: return 16'd162;
    endcase
  endfunction

  task automatic push_wr(input logic [1:0] addr, input logic [7:0] data);
    exp_q.push_back({1'b0, addr, data});
  endtask

  task automatic push_rd(input logic [7:0] data);
    exp_q.push_back({1'b1, 2'b00, data});
    exp_rx_q.push_back(data);
  endtask

  task automatic push_init(input logic [1:0] cfg);
    logic [15:0] d;
    d = tb_div(cfg);
    push_wr(2'b10, d[7:0]);
    push_wr(2'b11, d[15:8]);
  endtask

  // Bus monitor / scoreboard
  logic       prev_iocs = 1'b0;
  logic [1:0] prev_addr = 2'b00;
  logic       prev_rxv = 1'b0;
  always @(negedge clk) begin
    logic [31:0] exp;
    if (iocs === 1'b1) begin
      exp = (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'hDEAD_BEEF;
      check("bus_access", 32'({iorw, ioaddr, databus}), exp);
      // only the divisor low->high pair may be back to back
      check("iocs_gap", 32'(prev_iocs && !(prev_addr == 2'b10 && ioaddr == 2'b11)), 0);
    end
    if (rx_valid === 1'b1) begin
      exp = (exp_rx_q.size() > 0) ? 32'(exp_rx_q.pop_front()) : 32'hDEAD_BEEF;
      check("rx_char", 32'(rx_char), exp);
      check("rx_valid_pulse", 32'(prev_rxv), 0);
    end
    if (tx_ack === 1'b1)
      check("tx_ack_in_write", 32'({iocs, iorw, ioaddr}), 32'(4'b1000));
    prev_iocs = (iocs === 1'b1);
    prev_addr = ioaddr;
    prev_rxv  = (rx_valid === 1'b1);
  end

  // driver tasks
  // One cycle; the SPART model drops rda once read, the user drops tx_req once acked
  task automatic step();
    @(negedge clk);
    #1;
    if (iocs === 1'b1 && iorw === 1'b1 && ioaddr === 2'b00) begin
      rda = 1'b0;
      rd_cnt++;
    end
    if (tx_ack === 1'b1) begin
      tx_req = 1'b0;
      ack_cnt++;
    end
  endtask

  task automatic run_until_done(input string tag, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || exp_rx_q.size() != 0 || rda || tx_req) && n < budget) begin
      step();
      n++;
    end
    repeat (3) step();
    check(tag, 32'({16'(exp_q.size() + exp_rx_q.size()), 6'd0, rda, tx_req}), 0);
  endtask

  initial begin
    int a0;
    // reset state
    rst = 1'b0;
    br_cfg = 2'b01;
    repeat (3) @(negedge clk);
    check("rst_iocs", 32'(iocs), 0);
    check("rst_iorw", 32'(iorw), 1);
    check("rst_ioaddr", 32'(ioaddr), 0);
    check("rst_bus_z", 32'(databus === 8'hzz), 1);
    check("rst_rx", 32'({rx_char, rx_valid, tx_ack}), 0);

    // divisor programming for 9600
    push_init(2'b01);
    rst = 1'b1;
    run_until_done("init_9600", 40);
    check("idle_iocs", 32'(iocs), 0);
    check("idle_state", 32'(dbg_state), 32'(ST_IDLE));

    // single receive
    spart_rx_data = 8'h41;
    push_rd(8'h41);
`ifdef SPART_DRIVER_ECHO_EN
    push_wr(2'b00, 8'h41);
`endif
    rda = 1'b1;
    run_until_done("rx_41", 40);

    // transmit held off by tbr=0
    a0 = ack_cnt;
    tbr = 1'b0;
    tx_char = 8'h5A;
    tx_req = 1'b1;
    push_wr(2'b00, 8'h5A);
    repeat (10) step();
    check("tx_hold_tbr", 32'(exp_q.size()), 1);
    check("tx_hold_ack", 32'(ack_cnt - a0), 0);
    tbr = 1'b1;
    run_until_done("tx_5A", 40);
    check("tx_ack_count", 32'(ack_cnt - a0), 1);

    // receive wins over a same-cycle transmit
    a0 = ack_cnt;
    spart_rx_data = 8'h42;
    tx_char = 8'h66;
    push_rd(8'h42);
`ifdef SPART_DRIVER_ECHO_EN
    push_wr(2'b00, 8'h42);
`endif
    push_wr(2'b00, 8'h66);
    rda = 1'b1;
    tx_req = 1'b1;
    run_until_done("rx_before_tx", 60);
    check("rx_tx_ack_count", 32'(ack_cnt - a0), 1);

    // baud change during a read -> divisor rewritten at next idle
    spart_rx_data = 8'h43;
    push_rd(8'h43);
    push_init(2'b11);
`ifdef SPART_DRIVER_ECHO_EN
    push_wr(2'b00, 8'h43);
`endif
    a0 = rd_cnt;
    rda = 1'b1;
    for (int i = 0; i < 20 && rd_cnt == a0; i++) step();
    br_cfg = 2'b11;
    run_until_done("rebaud_38400", 60);

    // random transmit bytes
    for (int i = 0; i < 4; i++) begin
      tx_char = 8'($urandom_range(0, 255));
      push_wr(2'b00, tx_char);
      tx_req = 1'b1;
      run_until_done("tx_rand", 40);
    end

`ifdef SPART_DRIVER_ECHO_EN
    // echo goes out before a pending user byte; second rda held meanwhile
    a0 = ack_cnt;
    tbr = 1'b0;
    tx_char = 8'h55;
    tx_req = 1'b1;
    spart_rx_data = 8'h33;
    push_rd(8'h33);
    rda = 1'b1;
    for (int i = 0; i < 20 && rda; i++) step();
    spart_rx_data = 8'h77;
    rda = 1'b1;
    repeat (8) step();
    check("echo_hold_q", 32'(exp_q.size()), 0);
    check("echo_hold_rda", 32'(rda), 1);
    push_wr(2'b00, 8'h33);
    push_rd(8'h77);
    push_wr(2'b00, 8'h77);
    push_wr(2'b00, 8'h55);
    tbr = 1'b1;
    run_until_done("echo_order", 80);
    check("echo_ack_count", 32'(ack_cnt - a0), 1);
`endif

    // reset again with a received byte on record
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst2_rx_char", 32'(rx_char), 0);
    check("rst2_iocs", 32'(iocs), 0);
    push_init(2'b11);
    rst = 1'b1;
    run_until_done("reinit_38400", 40);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
